// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: framer states, error causes, byte width.
package uart_pkg;

  localparam int unsigned BYTE_SIZE = 8;

  typedef enum logic [2:0] {
    StHunt    = 3'd0,
    StHeader  = 3'd1,
    StPayload = 3'd2,
    StCheck   = 3'd3,
    StHold    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

endpackage

// File: rtl/gap_timer.sv
// Counts consecutive enabled cycles without a clear; flags the cycle that completes the limit.
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] Sat  = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != Sat) begin
      count_d = count_q + 1'b1;
    end
  end

  // Asserted while the cycle in progress is the last idle cycle allowed.
  assign expired = enable && !clear && (count_q >= Last);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Assembles START/header/payload/checksum frames from a byte stream and holds each
// completed frame until the downstream consumer takes it.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned HEADER_BYTES      = 4,
  parameter int unsigned MAX_PAYLOAD_BYTES = 64,
  parameter logic [7:0]  START_BYTE        = 8'hBB,
  parameter int unsigned TIMEOUT_CYCLES    = 100000
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               ll_valid_in,
  input  logic [BYTE_SIZE-1:0]               ll_byte_in,
  output logic                               ll_ready_out,
  output logic [BYTE_SIZE*HEADER_BYTES-1:0]  header_out,
  output logic [BYTE_SIZE*MAX_PAYLOAD_BYTES-1:0] message_out,
  output logic [BYTE_SIZE-1:0]               len_out,
  output logic                               valid_out,
  input  logic                               ctrl_ready_in,
  output logic                               err_out,
  output logic [1:0]                         err_code_out
);

  localparam int unsigned IdxW   = 16;
  localparam logic [7:0]  MaxLen = 8'(MAX_PAYLOAD_BYTES);

  state_e                               state_q, state_d;
  logic [BYTE_SIZE*HEADER_BYTES-1:0]      header_q, header_d;
  logic [BYTE_SIZE*MAX_PAYLOAD_BYTES-1:0] message_q, message_d;
  logic [BYTE_SIZE-1:0]                   len_q, len_d;
  logic [IdxW-1:0]                        idx_q, idx_d;
  logic [BYTE_SIZE-1:0]                   csum_q, csum_d;
  logic                                   valid_q, valid_d;
  logic                                   err_q, err_d;
  err_code_e                              code_q, code_d;
  logic                                   ready_q;

  logic consume;
  logic in_frame;
  logic expired;

  assign consume  = ll_valid_in && ready_q;
  assign in_frame = (state_q == StHeader) || (state_q == StPayload) || (state_q == StCheck);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (consume),
    .enable (in_frame),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    header_d  = header_q;
    message_d = message_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    code_d    = code_q;

    case (state_q)
      StHunt: begin
        if (consume && ll_byte_in == START_BYTE) begin
          state_d = StHeader;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      StHeader: begin
        if (consume) begin
          for (int i = 0; i < HEADER_BYTES; i++) begin
            if (idx_q == IdxW'(i)) header_d[BYTE_SIZE*i +: BYTE_SIZE] = ll_byte_in;
          end
          csum_d = csum_q ^ ll_byte_in;
          if (idx_q == '0 && (ll_byte_in == '0 || ll_byte_in > MaxLen)) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = StHunt;
          end else if (idx_q == IdxW'(HEADER_BYTES - 1)) begin
            // With a one-byte header the length is the byte arriving now.
            len_d   = (idx_q == '0) ? ll_byte_in : header_q[BYTE_SIZE-1:0];
            idx_d   = '0;
            state_d = StPayload;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StPayload: begin
        if (consume) begin
          for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
            if (idx_q == IdxW'(i)) message_d[BYTE_SIZE*i +: BYTE_SIZE] = ll_byte_in;
          end
          csum_d = csum_q ^ ll_byte_in;
          if (idx_q + 1'b1 == IdxW'(len_q)) begin
            state_d = StCheck;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StCheck: begin
        if (consume) begin
          if (ll_byte_in == csum_q) begin
            valid_d = 1'b1;
            state_d = StHold;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = StHunt;
          end
        end
      end
      StHold: begin
        if (ctrl_ready_in) begin
          valid_d = 1'b0;
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase

    // expired is only raised in a frame state on a cycle with no consumed byte.
    if (expired) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = StHunt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StHunt;
      header_q  <= '0;
      message_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      header_q  <= header_d;
      message_q <= message_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
      ready_q   <= (state_d != StHold);
    end
  end

  assign ll_ready_out = ready_q;
  assign header_out   = header_q;
  assign message_out  = message_q;
  assign len_out      = len_q;
  assign valid_out    = valid_q;
  assign err_out      = err_q;
  assign err_code_out = code_q;

endmodule
